// File: rtl/leaderboard_ranked.sv
// leaderboard_ranked
// Two ranked score boards (fast: lower time wins, slow: higher time wins),
// DEPTH entries each, fed by a one-cycle score strobe from the stopwatch.
//
// Ports
//   clk            rising-edge system clock
//   reset          asynchronous, active-high; clears every register
//   score_valid    score_time/score_mode are valid this cycle
//   score_time     time to rank
//   score_mode     01 = slow board, 10 = fast board, 00/11 = ignored
//   clear_mode     bit0 clears slow board, bit1 clears fast board
//   rd_mode        read select: 0 = fast board, 1 = slow board
//   rd_rank        read rank, 0 = best
//   rd_time        stored time at rd_mode/rd_rank (0 when out of range)
//   rd_filled      selected entry holds a score
//   mode_led       11 = fast shown, 01 = slow shown, 00 = rank out of range
//   rank_led       thermometer of rd_rank (rank r -> low r+1 bits set)
//   fast_count     filled fast entries
//   slow_count     filled slow entries
//   new_rank_pulse one-hot rank where the last score landed, one cycle
//   sound_toggle   bit r inverts on every insertion at rank r
//   reject_pulse   legal score that did not place, one cycle
module leaderboard_ranked #(
   parameter int TIME_W = 6,
   parameter int DEPTH  = 3,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              score_valid,
   input  logic [TIME_W-1:0] score_time,
   input  logic [1:0]        score_mode,
   input  logic [1:0]        clear_mode,
   input  logic              rd_mode,
   input  logic [IDX_W-1:0]  rd_rank,
   output logic [TIME_W-1:0] rd_time,
   output logic              rd_filled,
   output logic [1:0]        mode_led,
   output logic [DEPTH-1:0]  rank_led,
   output logic [IDX_W:0]    fast_count,
   output logic [IDX_W:0]    slow_count,
   output logic [DEPTH-1:0]  new_rank_pulse,
   output logic [DEPTH-1:0]  sound_toggle,
   output logic              reject_pulse
);

   typedef struct packed {
      logic              valid;
      logic [TIME_W-1:0] t;
   } entry_t;

   typedef entry_t [DEPTH-1:0] board_t;

   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

   board_t fast_q, slow_q;
   board_t fast_next, slow_next;
   logic   fast_hit, slow_hit;
   logic [DEPTH-1:0] fast_oh, slow_oh;

   // Rank-ordered insert. The board is kept sorted, so the first entry that
   // is empty or strictly worse than the score is the landing slot; using a
   // strict compare puts ties behind existing equal scores.
   function automatic board_t place(
      input  board_t            q,
      input  logic              is_fast,
      input  logic [TIME_W-1:0] score,
      output logic              hit,
      output logic [DEPTH-1:0]  onehot
   );
      board_t nb;
      int     pos;
      logic   better;
      // NOTE: function locals are scratch values, so blocking '=' is correct
      // here; only the state registers below use '<='.
      nb     = q;
      hit    = 1'b0;
      pos    = 0;
      onehot = '0;
      for (int r = 0; r < DEPTH; r++) begin
         better = !q[r].valid || (is_fast ? (score < q[r].t) : (score > q[r].t));
         if (!hit && better) begin
            hit = 1'b1;
            pos = r;
         end
      end
      if (hit) begin
         // Shift the worse entries down one rank; the last one falls off.
         for (int r = DEPTH - 1; r > 0; r--) begin
            if (r > pos) nb[r] = q[r-1];
         end
         nb[pos].valid = 1'b1;
         nb[pos].t     = score;
         onehot[pos]   = 1'b1;
      end
      return nb;
   endfunction

   always_comb begin
      fast_next = place(fast_q, 1'b1, score_time, fast_hit, fast_oh);
      slow_next = place(slow_q, 1'b0, score_time, slow_hit, slow_oh);
   end

   // A clear on the same edge suppresses a score aimed at that board.
   logic fast_go, slow_go;
   assign fast_go = score_valid && (score_mode == 2'b10) && !clear_mode[1];
   assign slow_go = score_valid && (score_mode == 2'b01) && !clear_mode[0];

   logic [DEPTH-1:0] placed;
   assign placed = ((fast_go && fast_hit) ? fast_oh : '0) |
                   ((slow_go && slow_hit) ? slow_oh : '0);

   // NOTE: the boards are only DEPTH registers each and must read back as
   // empty straight after reset, so they sit in the async reset like the rest.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fast_q         <= '0;
         slow_q         <= '0;
         fast_count     <= '0;
         slow_count     <= '0;
         new_rank_pulse <= '0;
         sound_toggle   <= '0;
         reject_pulse   <= 1'b0;
      end else begin
         if (clear_mode[1]) begin
            fast_q     <= '0;
            fast_count <= '0;
         end else if (fast_go && fast_hit) begin
            fast_q     <= fast_next;
            fast_count <= (fast_count == DEPTH_C) ? fast_count : fast_count + 1'b1;
         end
         if (clear_mode[0]) begin
            slow_q     <= '0;
            slow_count <= '0;
         end else if (slow_go && slow_hit) begin
            slow_q     <= slow_next;
            slow_count <= (slow_count == DEPTH_C) ? slow_count : slow_count + 1'b1;
         end
         new_rank_pulse <= placed;
         sound_toggle   <= sound_toggle ^ placed;
         reject_pulse   <= (fast_go && !fast_hit) || (slow_go && !slow_hit);
      end
   end

   // Read path: combinational from the board registers.
   board_t rd_board;
   logic   in_range;

   always_comb begin
      rd_board  = rd_mode ? slow_q : fast_q;
      in_range  = (int'(rd_rank) < DEPTH);
      rd_time   = '0;
      rd_filled = 1'b0;
      mode_led  = 2'b00;
      rank_led  = '0;
      if (in_range) begin
         rd_time   = rd_board[rd_rank].t;
         rd_filled = rd_board[rd_rank].valid;
         mode_led  = rd_mode ? 2'b01 : 2'b11;
         for (int r = 0; r < DEPTH; r++) begin
            rank_led[r] = (int'(rd_rank) >= r);
         end
      end
   end

endmodule

// File: tb/tb_leaderboard_ranked.sv
// Directed, table-driven bench for leaderboard_ranked (TIME_W=6, DEPTH=3).
module tb_leaderboard_ranked;

   logic       clk = 1'b0;
   logic       reset;
   logic       score_valid;
   logic [5:0] score_time;
   logic [1:0] score_mode;
   logic [1:0] clear_mode;
   logic       rd_mode;
   logic [1:0] rd_rank;
   logic [5:0] rd_time;
   logic       rd_filled;
   logic [1:0] mode_led;
   logic [2:0] rank_led;
   logic [2:0] fast_count;
   logic [2:0] slow_count;
   logic [2:0] new_rank_pulse;
   logic [2:0] sound_toggle;
   logic       reject_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   leaderboard_ranked #(.TIME_W(6), .DEPTH(3), .IDX_W(2)) dut (
      .clk(clk), .reset(reset),
      .score_valid(score_valid), .score_time(score_time), .score_mode(score_mode),
      .clear_mode(clear_mode), .rd_mode(rd_mode), .rd_rank(rd_rank),
      .rd_time(rd_time), .rd_filled(rd_filled), .mode_led(mode_led),
      .rank_led(rank_led), .fast_count(fast_count), .slow_count(slow_count),
      .new_rank_pulse(new_rank_pulse), .sound_toggle(sound_toggle),
      .reject_pulse(reject_pulse)
   );

   typedef struct packed {
      logic       v;
      logic [1:0] mode;
      logic [5:0] t;
      logic [1:0] clr;
      logic       rdm;
      logic [1:0] rdr;
      logic [5:0] e_time;
      logic       e_filled;
      logic [1:0] e_mled;
      logic [2:0] e_rled;
      logic [2:0] e_fcnt;
      logic [2:0] e_scnt;
      logic [2:0] e_nrp;
      logic [2:0] e_snd;
      logic       e_rej;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then sample after the rise.
   task automatic step(input logic v, input logic [1:0] mode, input logic [5:0] t,
                       input logic [1:0] clr, input logic rdm, input logic [1:0] rdr);
      @(negedge clk);
      score_valid = v;
      score_mode  = mode;
      score_time  = t;
      clear_mode  = clr;
      rd_mode     = rdm;
      rd_rank     = rdr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            v  mode   t      clr    rdm  rdr  | time  fil mled   rled    fc    sc    nrp     snd     rej
      vecs[0]  = '{1'b1, 2'b01, 6'd10, 2'b00, 1'b1, 2'd0, 6'd10, 1'b1, 2'b01, 3'b001, 3'd0, 3'd1, 3'b001, 3'b001, 1'b0};
      vecs[1]  = '{1'b1, 2'b01, 6'd30, 2'b00, 1'b1, 2'd0, 6'd30, 1'b1, 2'b01, 3'b001, 3'd0, 3'd2, 3'b001, 3'b000, 1'b0};
      vecs[2]  = '{1'b1, 2'b01, 6'd20, 2'b00, 1'b1, 2'd1, 6'd20, 1'b1, 2'b01, 3'b011, 3'd0, 3'd3, 3'b010, 3'b010, 1'b0};
      vecs[3]  = '{1'b0, 2'b00, 6'd0,  2'b00, 1'b1, 2'd2, 6'd10, 1'b1, 2'b01, 3'b111, 3'd0, 3'd3, 3'b000, 3'b010, 1'b0};
      vecs[4]  = '{1'b1, 2'b10, 6'd12, 2'b00, 1'b0, 2'd0, 6'd12, 1'b1, 2'b11, 3'b001, 3'd1, 3'd3, 3'b001, 3'b011, 1'b0};
      vecs[5]  = '{1'b1, 2'b10, 6'd5,  2'b00, 1'b0, 2'd0, 6'd5,  1'b1, 2'b11, 3'b001, 3'd2, 3'd3, 3'b001, 3'b010, 1'b0};
      vecs[6]  = '{1'b1, 2'b10, 6'd40, 2'b00, 1'b0, 2'd2, 6'd40, 1'b1, 2'b11, 3'b111, 3'd3, 3'd3, 3'b100, 3'b110, 1'b0};
      vecs[7]  = '{1'b1, 2'b10, 6'd50, 2'b00, 1'b0, 2'd2, 6'd40, 1'b1, 2'b11, 3'b111, 3'd3, 3'd3, 3'b000, 3'b110, 1'b1};
      vecs[8]  = '{1'b0, 2'b00, 6'd0,  2'b00, 1'b0, 2'd1, 6'd12, 1'b1, 2'b11, 3'b011, 3'd3, 3'd3, 3'b000, 3'b110, 1'b0};
      vecs[9]  = '{1'b1, 2'b11, 6'd1,  2'b00, 1'b0, 2'd0, 6'd5,  1'b1, 2'b11, 3'b001, 3'd3, 3'd3, 3'b000, 3'b110, 1'b0};
      vecs[10] = '{1'b1, 2'b01, 6'd20, 2'b00, 1'b1, 2'd2, 6'd20, 1'b1, 2'b01, 3'b111, 3'd3, 3'd3, 3'b100, 3'b010, 1'b0};
      vecs[11] = '{1'b0, 2'b00, 6'd0,  2'b00, 1'b1, 2'd0, 6'd30, 1'b1, 2'b01, 3'b001, 3'd3, 3'd3, 3'b000, 3'b010, 1'b0};
      vecs[12] = '{1'b0, 2'b00, 6'd0,  2'b00, 1'b1, 2'd3, 6'd0,  1'b0, 2'b00, 3'b000, 3'd3, 3'd3, 3'b000, 3'b010, 1'b0};
      vecs[13] = '{1'b1, 2'b01, 6'd7,  2'b01, 1'b1, 2'd0, 6'd0,  1'b0, 2'b01, 3'b001, 3'd3, 3'd0, 3'b000, 3'b010, 1'b0};
      vecs[14] = '{1'b1, 2'b10, 6'd3,  2'b01, 1'b0, 2'd0, 6'd3,  1'b1, 2'b11, 3'b001, 3'd3, 3'd0, 3'b001, 3'b011, 1'b0};
      vecs[15] = '{1'b0, 2'b00, 6'd0,  2'b00, 1'b0, 2'd2, 6'd12, 1'b1, 2'b11, 3'b111, 3'd3, 3'd0, 3'b000, 3'b011, 1'b0};
      vecs[16] = '{1'b1, 2'b10, 6'd1,  2'b10, 1'b0, 2'd0, 6'd0,  1'b0, 2'b11, 3'b001, 3'd0, 3'd0, 3'b000, 3'b011, 1'b0};
      vecs[17] = '{1'b1, 2'b10, 6'd0,  2'b00, 1'b0, 2'd0, 6'd0,  1'b1, 2'b11, 3'b001, 3'd1, 3'd0, 3'b001, 3'b010, 1'b0};
      vecs[18] = '{1'b1, 2'b10, 6'd0,  2'b00, 1'b0, 2'd1, 6'd0,  1'b1, 2'b11, 3'b011, 3'd2, 3'd0, 3'b010, 3'b000, 1'b0};
      vecs[19] = '{1'b1, 2'b01, 6'd0,  2'b00, 1'b1, 2'd0, 6'd0,  1'b1, 2'b01, 3'b001, 3'd2, 3'd1, 3'b001, 3'b001, 1'b0};
      vecs[20] = '{1'b1, 2'b00, 6'd5,  2'b00, 1'b1, 2'd0, 6'd0,  1'b1, 2'b01, 3'b001, 3'd2, 3'd1, 3'b000, 3'b001, 1'b0};

      reset       = 1'b1;
      score_valid = 1'b0;
      score_time  = '0;
      score_mode  = 2'b00;
      clear_mode  = 2'b00;
      rd_mode     = 1'b0;
      rd_rank     = 2'd0;

      // Reset state, sampled while reset is still held.
      repeat (2) @(posedge clk);
      #1;
      check("reset rd_time",      32'(rd_time), 32'd0);
      check("reset rd_filled",    32'(rd_filled), 32'd0);
      check("reset mode_led",     32'(mode_led), 32'b11);
      check("reset rank_led",     32'(rank_led), 32'b001);
      check("reset fast_count",   32'(fast_count), 32'd0);
      check("reset slow_count",   32'(slow_count), 32'd0);
      check("reset new_rank",     32'(new_rank_pulse), 32'd0);
      check("reset sound_toggle", 32'(sound_toggle), 32'd0);
      check("reset reject",       32'(reject_pulse), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].v, vecs[i].mode, vecs[i].t, vecs[i].clr, vecs[i].rdm, vecs[i].rdr);
         check($sformatf("row%0d rd_time", i),      32'(rd_time),        32'(vecs[i].e_time));
         check($sformatf("row%0d rd_filled", i),    32'(rd_filled),      32'(vecs[i].e_filled));
         check($sformatf("row%0d mode_led", i),     32'(mode_led),       32'(vecs[i].e_mled));
         check($sformatf("row%0d rank_led", i),     32'(rank_led),       32'(vecs[i].e_rled));
         check($sformatf("row%0d fast_count", i),   32'(fast_count),     32'(vecs[i].e_fcnt));
         check($sformatf("row%0d slow_count", i),   32'(slow_count),     32'(vecs[i].e_scnt));
         check($sformatf("row%0d new_rank", i),     32'(new_rank_pulse), 32'(vecs[i].e_nrp));
         check($sformatf("row%0d sound_toggle", i), 32'(sound_toggle),   32'(vecs[i].e_snd));
         check($sformatf("row%0d reject", i),       32'(reject_pulse),   32'(vecs[i].e_rej));
      end

      // Refill the fast board to full: 10, 20, 30 land at ranks 0, 1, 2.
      step(1'b0, 2'b00, 6'd0,  2'b10, 1'b0, 2'd0);
      step(1'b1, 2'b10, 6'd10, 2'b00, 1'b0, 2'd0);
      step(1'b1, 2'b10, 6'd20, 2'b00, 1'b0, 2'd0);
      step(1'b1, 2'b10, 6'd30, 2'b00, 1'b0, 2'd0);
      check("refill fast_count",   32'(fast_count), 32'd3);
      check("refill rd_time",      32'(rd_time), 32'd10);
      check("refill sound_toggle", 32'(sound_toggle), 32'b110);

      // Asynchronous reset between edges clears everything before the next edge.
      @(negedge clk);
      score_valid = 1'b0;
      score_mode  = 2'b00;
      #2;
      reset = 1'b1;
      #1;
      check("async fast_count",   32'(fast_count), 32'd0);
      check("async slow_count",   32'(slow_count), 32'd0);
      check("async rd_time",      32'(rd_time), 32'd0);
      check("async rd_filled",    32'(rd_filled), 32'd0);
      check("async sound_toggle", 32'(sound_toggle), 32'd0);
      #1;
      reset       = 1'b0;
      score_valid = 1'b1;
      score_mode  = 2'b10;
      score_time  = 6'd9;
      @(posedge clk);
      #1;
      check("post-reset fast_count", 32'(fast_count), 32'd1);
      check("post-reset rd_time",    32'(rd_time), 32'd9);
      check("post-reset new_rank",   32'(new_rank_pulse), 32'b001);
      check("post-reset toggle",     32'(sound_toggle), 32'b001);

      // Pulse drops after one cycle.
      step(1'b0, 2'b00, 6'd0, 2'b00, 1'b0, 2'd0);
      check("pulse clears new_rank", 32'(new_rank_pulse), 32'd0);
      check("pulse clears toggle",   32'(sound_toggle), 32'b001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
